imem_program_loader: RTL

- Writer-side counterpart of the opcode decoder: packs instruction fields into 16-bit words and writes them sequentially into instruction memory before the CPU runs.
- Sits between a test or host front end and the instruction memory write port.
- The CPU is held in reset by the system while `busy` is high.
- Encoding matches the decoder opcode map: 000 R-type, 001 lw, 010 sw, 011 jump, 100 addi; 101–111 are illegal.

---
 rtl/imem_program_loader.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/imem_program_loader.sv
// imem_program_loader: packs instruction fields into 16-bit words and writes
// them sequentially into instruction memory from BASE_ADDR upward.
// Optional feature macro: IMEM_CHECKSUM_EN adds a running XOR `checksum` of
// every word written in the current session.
module imem_program_loader #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [2:0]        in_rs,
  input  logic [2:0]        in_rt,
  input  logic [2:0]        in_rd,
  input  logic [3:0]        in_funct,
  input  logic [6:0]        in_imm,
  input  logic [12:0]       in_jaddr,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
`ifdef IMEM_CHECKSUM_EN
  output logic [15:0]       checksum,
`endif
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  // Opcode map shared with the decoder; 101..111 have no encoding.
  function automatic logic is_legal(input logic [2:0] op);
    return (op <= 3'b100);
  endfunction

  function automatic logic [15:0] encode(
    input logic [2:0]  op,
    input logic [2:0]  rs,
    input logic [2:0]  rt,
    input logic [2:0]  rd,
    input logic [3:0]  funct,
    input logic [6:0]  imm,
    input logic [12:0] jaddr
  );
    logic [15:0] w;
    case (op)
      3'b000:  w = {op, rs, rt, rd, funct};
      3'b011:  w = {op, jaddr};
      default: w = {op, rs, rt, imm};
    endcase
    return w;
  endfunction

  state_t              state_q, state_d;
  logic [15:0]         word_p1_q, word_p1_d;
  logic                last_p1_q, last_p1_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [1:0]          code_q, code_d;
  logic                we_q, we_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
`ifdef IMEM_CHECKSUM_EN
  logic [15:0]         cks_q, cks_d;
`endif

  // Stage p0 -> p1: next-state, accepted word and session status
  always_comb begin
    state_d   = state_q;
    word_p1_d = word_p1_q;
    last_p1_d = last_p1_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    err_d     = err_q;
    code_d    = code_q;
`ifdef IMEM_CHECKSUM_EN
    cks_d     = cks_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_ACCEPT;
          addr_d  = BASE;
          cnt_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
`ifdef IMEM_CHECKSUM_EN
          cks_d   = '0;
`endif
        end
      end
      S_ACCEPT: begin
        if (in_valid) begin
          if (is_legal(in_op)) begin
            word_p1_d = encode(in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_jaddr);
            last_p1_d = in_last;
            state_d   = S_WRITE;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_ILLEGAL;
            state_d = S_ERR;
          end
        end
      end
      S_WRITE: begin
        cnt_d = cnt_q + (ADDR_W+1)'(1);
`ifdef IMEM_CHECKSUM_EN
        cks_d = cks_q ^ word_p1_q;
`endif
        if (last_p1_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (addr_q == '1) begin
          // Address space exhausted: abort rather than wrap onto word 0.
          err_d   = 1'b1;
          code_d  = ERR_OVERFLOW;
          state_d = S_ERR;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_ACCEPT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Handshake/strobe outputs are registered from the state being entered.
    we_d    = (state_d == S_WRITE);
    ready_d = (state_d == S_ACCEPT);
    busy_d  = (state_d == S_ACCEPT) || (state_d == S_WRITE);
  end

  // Stage p1 register: FSM state and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      word_p1_q <= '0;
      last_p1_q <= 1'b0;
      addr_q    <= BASE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
      we_q      <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
      cks_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      word_p1_q <= word_p1_d;
      last_p1_q <= last_p1_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      code_q    <= code_d;
      we_q      <= we_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
`ifdef IMEM_CHECKSUM_EN
      cks_q     <= cks_d;
`endif
    end
  end

  // A reset arriving during WRITE must not let that cycle's strobe through.
  assign imem_we    = we_q & ~rst;
  assign in_ready   = ready_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = word_p1_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = code_q;
  assign word_count = cnt_q;
`ifdef IMEM_CHECKSUM_EN
  assign checksum   = cks_q;
`endif

endmodule
